// File: rtl/puf_serial_vote.sv
`default_nettype none
// ============================================================================
// Module   : puf_serial_vote
// Brief    : Serial ring-oscillator PUF. Per response bit an LFSR picks one
//            oscillator from each bank; a majority of VOTES window counts
//            decides the bit.
// Revision : 1.0 - initial release
// ============================================================================
module puf_serial_vote #(
    parameter int NUM_RO     = 16,
    parameter int RESP_BITS  = 8,
    parameter int CNT_W      = 16,
    parameter int WINDOW     = 1024,
    parameter int SETTLE_CYC = 8,
    parameter int VOTES      = 3,
    parameter logic [2*$clog2(NUM_RO)-1:0] POLY = (2*$clog2(NUM_RO))'(8'hB8)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [2*$clog2(NUM_RO)-1:0]   challenge,
    input  logic [NUM_RO-1:0]             ro_a,
    input  logic [NUM_RO-1:0]             ro_b,
    output logic [NUM_RO-1:0]             ro_en_a,
    output logic [NUM_RO-1:0]             ro_en_b,
    output logic                          busy,
    output logic                          done,
    output logic [RESP_BITS-1:0]          response,
    output logic                          tie_seen
);

    localparam int c_sel_w   = $clog2(NUM_RO);
    localparam int c_chal_w  = 2 * c_sel_w;
    localparam int c_cyc_max = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
    localparam int c_cyc_w   = $clog2(c_cyc_max + 1);
    localparam int c_vote_w  = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int c_win_w   = $clog2(VOTES + 1);
    localparam int c_bit_w   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [c_cyc_w-1:0]  c_settle_last = c_cyc_w'(SETTLE_CYC - 1);
    localparam logic [c_cyc_w-1:0]  c_window_last = c_cyc_w'(WINDOW - 1);
    localparam logic [c_vote_w-1:0] c_vote_last   = c_vote_w'(VOTES - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last    = c_bit_w'(RESP_BITS - 1);
    localparam logic [c_win_w-1:0]  c_majority    = c_win_w'(VOTES / 2);
    localparam logic [CNT_W-1:0]    c_cnt_max     = {CNT_W{1'b1}};
    localparam logic [c_chal_w-1:0] c_seed_zero   = c_chal_w'(1);
    localparam logic [NUM_RO-1:0]   c_onehot_base = NUM_RO'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_COMPARE = 3'd3,
        S_NEXT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [c_chal_w-1:0]    r_lfsr;
    logic [c_cyc_w-1:0]     r_cyc;
    logic [c_vote_w-1:0]    r_vote_idx;
    logic [c_win_w-1:0]     r_wins;
    logic [c_bit_w-1:0]     r_bit_idx;
    logic [RESP_BITS-1:0]   r_shadow;
    logic [RESP_BITS-1:0]   r_response;
    logic                   r_tie_seen;
    logic [CNT_W-1:0]       r_cnt_a;
    logic [CNT_W-1:0]       r_cnt_b;

    logic                   r_sel_a;
    logic                   r_sel_b;
    logic [1:0]             r_sync_a;
    logic [1:0]             r_sync_b;
    logic                   r_prev_a;
    logic                   r_prev_b;

    logic [c_sel_w-1:0]     w_idx_a;
    logic [c_sel_w-1:0]     w_idx_b;
    logic [c_chal_w-1:0]    w_lfsr_step;
    logic                   w_edge_a;
    logic                   w_edge_b;
    logic                   w_a_gt_b;
    logic                   w_a_eq_b;
    logic                   w_bit;
    logic [RESP_BITS-1:0]   w_shadow_upd;
    logic                   w_pair_en;
    logic                   w_busy;
    logic                   w_done;

    assign w_idx_a     = r_lfsr[c_sel_w-1:0];
    assign w_idx_b     = r_lfsr[c_chal_w-1:c_sel_w];
    assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? POLY : '0);
    assign w_edge_a    = r_sync_a[1] & ~r_prev_a;
    assign w_edge_b    = r_sync_b[1] & ~r_prev_b;
    assign w_a_gt_b    = (r_cnt_a > r_cnt_b);
    assign w_a_eq_b    = (r_cnt_a == r_cnt_b);
    assign w_bit       = (r_wins > c_majority);

    always_comb begin
        w_shadow_upd            = r_shadow;
        w_shadow_upd[r_bit_idx] = w_bit;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pair_en    = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_pair_en = 1'b1;
                if (r_cyc == c_settle_last) begin
                    w_state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                w_pair_en = 1'b1;
                if (r_cyc == c_window_last) begin
                    w_state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_pair_en    = 1'b1;
                w_state_next = (r_vote_idx == c_vote_last) ? S_NEXT : S_MEASURE;
            end
            S_NEXT: begin
                w_state_next = (r_bit_idx == c_bit_last) ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Edge detection: registered mux, two-flop synchroniser, prev flop
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel_a  <= 1'b0;
            r_sel_b  <= 1'b0;
            r_sync_a <= '0;
            r_sync_b <= '0;
            r_prev_a <= 1'b0;
            r_prev_b <= 1'b0;
        end else begin
            r_sel_a  <= ro_a[w_idx_a];
            r_sel_b  <= ro_b[w_idx_b];
            r_sync_a <= {r_sync_a[0], r_sel_a};
            r_sync_b <= {r_sync_b[0], r_sel_b};
            r_prev_a <= r_sync_a[1];
            r_prev_b <= r_sync_b[1];
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr     <= '0;
            r_cyc      <= '0;
            r_vote_idx <= '0;
            r_wins     <= '0;
            r_bit_idx  <= '0;
            r_shadow   <= '0;
            r_response <= '0;
            r_tie_seen <= 1'b0;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
        end else begin
            // Phase timer restarts on every state change
            if (w_state_next != r_state) begin
                r_cyc <= '0;
            end else if (r_state == S_SETTLE || r_state == S_MEASURE) begin
                r_cyc <= r_cyc + 1'b1;
            end

            if (w_state_next == S_MEASURE && r_state != S_MEASURE) begin
                r_cnt_a <= '0;
                r_cnt_b <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lfsr     <= (challenge == '0) ? c_seed_zero : challenge;
                        r_shadow   <= '0;
                        r_tie_seen <= 1'b0;
                        r_bit_idx  <= '0;
                        r_wins     <= '0;
                        r_vote_idx <= '0;
                    end
                end
                S_MEASURE: begin
                    if (w_edge_a && r_cnt_a != c_cnt_max) begin
                        r_cnt_a <= r_cnt_a + 1'b1;
                    end
                    if (w_edge_b && r_cnt_b != c_cnt_max) begin
                        r_cnt_b <= r_cnt_b + 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (w_a_gt_b) begin
                        r_wins <= r_wins + 1'b1;
                    end
                    if (w_a_eq_b) begin
                        r_tie_seen <= 1'b1;
                    end
                    if (r_vote_idx != c_vote_last) begin
                        r_vote_idx <= r_vote_idx + 1'b1;
                    end
                end
                S_NEXT: begin
                    r_shadow   <= w_shadow_upd;
                    r_wins     <= '0;
                    r_vote_idx <= '0;
                    r_lfsr     <= w_lfsr_step;
                    // Publish on the way into DONE so response is valid with done
                    if (r_bit_idx != c_bit_last) begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_response <= w_shadow_upd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ro_en_a  = w_pair_en ? (c_onehot_base << w_idx_a) : '0;
    assign ro_en_b  = w_pair_en ? (c_onehot_base << w_idx_b) : '0;
    assign busy     = w_busy;
    assign done     = w_done;
    assign response = r_response;
    assign tie_seen = r_tie_seen;

endmodule
`default_nettype wire

// File: tb/tb_puf_serial_vote.sv
`default_nettype none
// ============================================================================
// Module   : tb_puf_serial_vote
// Brief    : Directed self-checking bench for puf_serial_vote.
// Revision : 1.0 - initial release
// ============================================================================
module tb_puf_serial_vote;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        start6;
    logic [7:0]  challenge;
    logic [7:0]  challenge6;
    logic [15:0] ro_a;
    logic [15:0] ro_b;
    logic [15:0] en_a, en_b, en_a6, en_b6;
    logic        busy, done, tie_seen;
    logic        busy6, done6, tie6;
    logic [7:0]  response, response6;

    int per_a = 0;
    int per_b = 0;
    int tcyc  = 0;
    int total = 0;
    int bad   = 0;

    int          d_cyc, d_cnt;
    bit          b_ok;
    logic [15:0] ea1, eb1, ea55, eb55, ea57, eb57;
    logic        b449, b450;

    always #5 clock = ~clock;

    always @(negedge clock) tcyc <= tcyc + 1;

    // Oscillator model: square wave with a period of per_* clocks, 0 = stopped
    always_comb begin
        ro_a = (per_a != 0 && (tcyc % per_a) < per_a / 2) ? 16'hFFFF : 16'h0000;
        ro_b = (per_b != 0 && (tcyc % per_b) < per_b / 2) ? 16'hFFFF : 16'h0000;
    end

    puf_serial_vote #(
        .WINDOW(16), .SETTLE_CYC(4), .VOTES(3)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .ro_en_a(en_a), .ro_en_b(en_b),
        .busy(busy), .done(done), .response(response), .tie_seen(tie_seen)
    );

    puf_serial_vote #(
        .CNT_W(4), .WINDOW(64), .SETTLE_CYC(4), .VOTES(3)
    ) dut6 (
        .clock(clock), .reset(reset), .start(start6), .challenge(challenge6),
        .ro_a(ro_a), .ro_b(ro_b), .ro_en_a(en_a6), .ro_en_b(en_b6),
        .busy(busy6), .done(done6), .response(response6), .tie_seen(tie6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run: start accepted at cycle 0, outputs sampled #1 after edges 1..600
    task automatic run(input logic [7:0] chal, input int pulse_at, input bit hold);
        d_cyc = 0; d_cnt = 0; b_ok = 1'b1; b449 = 1'b0; b450 = 1'b0;
        ea1 = 'x; eb1 = 'x; ea55 = 'x; eb55 = 'x; ea57 = 'x; eb57 = 'x;
        @(negedge clock);
        challenge = chal;
        start     = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                d_cnt++;
                if (d_cyc == 0) d_cyc = k;
            end
            if (k <= 448 && busy !== 1'b1) b_ok = 1'b0;
            if (k == 1)   begin ea1  = en_a; eb1  = en_b; end
            if (k == 55)  begin ea55 = en_a; eb55 = en_b; end
            if (k == 57)  begin ea57 = en_a; eb57 = en_b; end
            if (k == 449) b449 = busy;
            if (k == 450) b450 = busy;
            if (k == pulse_at) start = 1'b1;
            else if (!hold)    start = 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start6 = 1'b0;
        challenge = 8'h00; challenge6 = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resp", response, 8'h00);
        check("rst_tie", tie_seen, 0);
        check("rst_en_a", en_a, 16'h0000);
        check("rst_en_b", en_b, 16'h0000);
        reset = 1'b0;

        // Test 1: bank A twice as fast
        per_a = 4; per_b = 8;
        run(8'h5A, 0, 1'b0);
        check("t1_done_cyc", d_cyc, 448);
        check("t1_done_cnt", d_cnt, 1);
        check("t1_busy_span", b_ok, 1);
        check("t1_busy_after", busy, 0);
        check("t1_resp", response, 8'hFF);
        check("t1_tie", tie_seen, 0);
        check("t1_en_a_bit0", ea1, 16'h0400);
        check("t1_en_b_bit0", eb1, 16'h0020);

        // Test 2: banks swapped
        per_a = 8; per_b = 4;
        run(8'h5A, 0, 1'b0);
        check("t2_resp", response, 8'h00);
        check("t2_tie", tie_seen, 0);

        // Test 3: zero challenge seeds the LFSR with 1
        per_a = 4; per_b = 8;
        run(8'h00, 0, 1'b0);
        check("t3_en_a_bit0", ea1, 16'h0002);
        check("t3_en_b_bit0", eb1, 16'h0001);
        check("t3_en_a_next", ea55, 16'h0000);
        check("t3_en_b_next", eb55, 16'h0000);
        check("t3_en_a_bit1", ea57, 16'h0100);
        check("t3_en_b_bit1", eb57, 16'h0800);
        check("t3_resp", response, 8'hFF);

        // Test 4a: identical banks, every vote a tie
        per_a = 4; per_b = 4;
        run(8'h5A, 0, 1'b0);
        check("t4a_resp", response, 8'h00);
        check("t4a_tie", tie_seen, 1);

        // Test 4b: bit0 votes A, B, A; later bits stopped oscillators (ties)
        per_a = 4; per_b = 0;
        fork
            run(8'h5A, 0, 1'b0);
            begin
                @(negedge clock);
                @(posedge clock);
                repeat (20) @(posedge clock);
                #1; per_a = 0; per_b = 4;
                repeat (17) @(posedge clock);
                #1; per_a = 4; per_b = 0;
                repeat (17) @(posedge clock);
                #1; per_a = 0; per_b = 0;
            end
        join
        check("t4b_resp", response, 8'h01);
        check("t4b_tie", tie_seen, 1);

        // Test 5: second start mid-run is ignored
        per_a = 4; per_b = 8;
        run(8'h5A, 100, 1'b0);
        check("t5_done_cyc", d_cyc, 448);
        check("t5_done_cnt", d_cnt, 1);
        check("t5_resp", response, 8'hFF);

        // Test 5: reset at cycle 200 aborts the run
        @(negedge clock);
        challenge = 8'h5A; start = 1'b1;
        @(posedge clock);
        #1; start = 1'b0;
        repeat (199) @(posedge clock);
        #1;
        check("t5_busy_pre_rst", busy, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_en_a", en_a, 16'h0000);
        check("t5_rst_en_b", en_b, 16'h0000);
        check("t5_rst_resp", response, 8'h00);
        reset = 1'b0;
        run(8'h5A, 0, 1'b0);
        check("t5_after_done_cyc", d_cyc, 448);
        check("t5_after_resp", response, 8'hFF);

        // start held high: ignored in DONE, accepted in the following IDLE
        run(8'h5A, 0, 1'b1);
        check("hold_done_cyc", d_cyc, 448);
        check("hold_busy_449", b449, 0);
        check("hold_busy_450", b450, 1);
        reset = 1'b1;
        @(posedge clock);
        #1; reset = 1'b0;

        // Test 6: 4-bit counters saturate on both banks
        per_a = 4; per_b = 4;
        d_cyc = 0;
        @(negedge clock);
        challenge6 = 8'h5A; start6 = 1'b1;
        @(posedge clock);
        #1; start6 = 1'b0;
        for (int k = 1; k <= 2000 && d_cyc == 0; k++) begin
            @(posedge clock);
            #1;
            if (done6) d_cyc = k;
        end
        check("t6_done_cyc", d_cyc, 1600);
        check("t6_resp", response6, 8'h00);
        check("t6_tie", tie6, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/puf_serial_vote.md
Name: puf_serial_vote

Overview:
- Parametrised successor of the 8-bit serial RO-PUF controller.
- Per response bit, a challenge-seeded Galois LFSR selects one ring oscillator from each of two banks and enables only that pair.
- Rising edges from the selected pair are counted over a fixed clock window, repeated VOTES times; the majority of (count_a > count_b) becomes the response bit.
- Adds a start/busy/done handshake, tie reporting and counter saturation. Sits between the two RO banks and the response consumer.

Parameters:
- NUM_RO, 16, oscillators per bank; power of 2, ≥2. SEL_W = log2(NUM_RO); CHAL_W = 2*SEL_W.
- RESP_BITS, 8, response width in bits.
- CNT_W, 16, edge-counter width; counters saturate.
- WINDOW, 1024, MEASURE cycles per vote; ≥1.
- SETTLE_CYC, 8, cycles after pair enable before the first vote; ≥3.
- VOTES, 3, measurements per bit; odd, ≥1.
- POLY, 8'hB8, Galois LFSR tap mask, CHAL_W bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- challenge  in  CHAL_W  LFSR seed; captured on accepted start
- ro_a  in  NUM_RO  bank A oscillator outputs (divided, < clock/2)
- ro_b  in  NUM_RO  bank B oscillator outputs
- ro_en_a  out  NUM_RO  one-hot enable, bank A
- ro_en_b  out  NUM_RO  one-hot enable, bank B
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse; response valid
- response  out  RESP_BITS  result; held until next accepted start
- tie_seen  out  1  sticky per run; any vote with count_a == count_b

Behaviour:
- Reset: state IDLE. response=0, done=0, busy=0, tie_seen=0, ro_en_a=ro_en_b=0, counters/LFSR/vote regs=0.
- Reset mid-run takes effect at the next edge; the run is discarded and response is cleared to 0.
- Seed: lfsr <= challenge, or 1 if challenge==0.
- Step: lfsr <= (lfsr>>1) ^ (lfsr[0] ? POLY : 0).
- Bit k uses the LFSR after k steps. idx_a = lfsr[SEL_W-1:0]; idx_b = lfsr[CHAL_W-1:SEL_W].
- ro_en_a = 1<<idx_a and ro_en_b = 1<<idx_b in SETTLE/MEASURE/COMPARE; 0 in IDLE, NEXT and DONE.
- Edge path per bank: registered mux select, 2-flop synchroniser, then prev flop. A rising edge is sync & ~prev. The path runs continuously.
- FSM:
  - IDLE: on start → capture seed, clear response shadow/tie_seen/bit_idx, busy=1, go SETTLE.
  - SETTLE: SETTLE_CYC cycles → MEASURE.
  - MEASURE: counters cleared on entry. WINDOW cycles, each counter +1 per detected edge, saturating at 2^CNT_W-1.
  - COMPARE (1 cycle): wins += (cnt_a > cnt_b); if equal, tie_seen <= 1 and the vote counts as 0. If vote_idx < VOTES-1 → MEASURE, else → NEXT.
  - NEXT (1 cycle): shadow[bit_idx] <= (wins > VOTES/2); clear wins/vote_idx; step LFSR. If bit_idx < RESP_BITS-1 → bit_idx+1, SETTLE; else → DONE.
  - DONE (1 cycle): response <= shadow, done=1, busy=0 next cycle → IDLE.
- Latency: done is high at exactly N = RESP_BITS*(SETTLE_CYC + VOTES*(WINDOW+1) + 1) cycles after the edge that accepted start.
- start while busy: ignored, no queuing.
- start in the DONE cycle: ignored.
- start held high: a new run begins on the cycle after DONE.
- Both counters saturated: counts as a tie.

Test Plan:
- Overrides used throughout: WINDOW=16, SETTLE_CYC=4, VOTES=3; otherwise defaults; challenge=8'h5A.
- Test 1: every ro_a toggles with period 4 clocks, every ro_b with period 8 → response=8'hFF, tie_seen=0, done pulse exactly 8*(4+3*17+1)=448 cycles after start, busy high for that span.
- Test 2: same as Test 1 with banks swapped → response=8'h00, tie_seen=0.
- Test 3: challenge=0 → seed 8'h01, bit0 ro_en_a=16'h0002 / ro_en_b=16'h0001; bit1 LFSR=8'hB8, ro_en_a=16'h0100 / ro_en_b=16'h0800.
- Test 4: identical frequencies on both banks → response=8'h00, tie_seen=1. Bank A faster in votes 1 and 3 only, bank B faster in vote 2, for bit0 → response[0]=1.
- Test 5: start pulsed again at cycle 100 of a run → ignored, single done at cycle 448. reset at cycle 200 → next cycle busy=0, ro_en=0, response=0; a following start completes normally.
- Test 6: CNT_W=4, WINDOW=64, both banks faster than 15 edges/window → counters stick at 15, every vote a tie, response=0, tie_seen=1.
